// File: rtl/sopc_multi_timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
package sopc_multi_timer_pkg;

  localparam logic [2:0] RegStatus   = 3'd0;
  localparam logic [2:0] RegControl  = 3'd1;
  localparam logic [2:0] RegPeriod   = 3'd2;
  localparam logic [2:0] RegSnapshot = 3'd3;
  localparam logic [2:0] RegPending  = 3'd4;

  localparam int unsigned CtrlIto         = 0;
  localparam int unsigned CtrlCont        = 1;
  localparam int unsigned CtrlStart       = 2;
  localparam int unsigned CtrlStop        = 3;
  localparam int unsigned CtrlPrescaleLsb = 8;
  localparam int unsigned CtrlPrescaleMsb = 15;

  localparam int unsigned StatusTo  = 0;
  localparam int unsigned StatusRun = 1;

endpackage

// File: rtl/sopc_multi_timer_channel.sv
// One timer channel: prescaler, down-counter, RUN/TO flags and its register file.
module sopc_multi_timer_channel
  import sopc_multi_timer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter int unsigned DEFAULT_PERIOD = 49999
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   status_we_i,
  input  logic                   control_we_i,
  input  logic                   period_we_i,
  input  logic                   snapshot_we_i,
  input  logic [DATA_WIDTH-1:0]  wdata_i,
  output logic [1:0]             status_o,
  output logic [15:0]            control_o,
  output logic [COUNT_WIDTH-1:0] period_o,
  output logic [COUNT_WIDTH-1:0] snapshot_o,
  output logic                   irq_o
);

  localparam logic [COUNT_WIDTH-1:0] ResetPeriod = COUNT_WIDTH'(DEFAULT_PERIOD);

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] period_q, snapshot_q;
  logic [7:0]             prescale_q, psc_cnt_q, psc_cnt_d;
  logic                   run_q, run_d, to_q, to_d;
  logic                   ito_q, cont_q, zero_q, reload_q;
  logic                   tick, count_zero;

  // Write-data bits above the counter width carry no meaning for this channel.
  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

  always_comb begin
    count_zero = (count_q == '0);
    tick       = run_q & (psc_cnt_q == prescale_q);

    psc_cnt_d = psc_cnt_q + 8'd1;
    if (!run_q || reload_q || tick) psc_cnt_d = '0;

    count_d = count_q;
    if (reload_q) begin
      count_d = period_q;
    end else if (tick) begin
      if (!count_zero) count_d = count_q - COUNT_WIDTH'(1);
      else if (cont_q) count_d = period_q;
    end

    // START has the final say over every source that clears RUN.
    run_d = run_q;
    if (reload_q || (control_we_i && wdata_i[CtrlStop]) || (count_zero && !cont_q)) begin
      run_d = 1'b0;
    end
    if (control_we_i && wdata_i[CtrlStart]) run_d = 1'b1;

    // A coincident clear drops a new timeout event.
    to_d = to_q | (count_zero & ~zero_q);
    if (status_we_i && wdata_i[StatusTo]) to_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      count_q    <= ResetPeriod;
      period_q   <= ResetPeriod;
      snapshot_q <= '0;
      prescale_q <= '0;
      psc_cnt_q  <= '0;
      run_q      <= 1'b0;
      to_q       <= 1'b0;
      ito_q      <= 1'b0;
      cont_q     <= 1'b0;
      zero_q     <= (ResetPeriod == '0);
      reload_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      psc_cnt_q <= psc_cnt_d;
      run_q     <= run_d;
      to_q      <= to_d;
      zero_q    <= count_zero;
      reload_q  <= period_we_i;
      if (period_we_i) period_q <= wdata_i[COUNT_WIDTH-1:0];
      if (snapshot_we_i) snapshot_q <= count_q;
      if (control_we_i) begin
        ito_q      <= wdata_i[CtrlIto];
        cont_q     <= wdata_i[CtrlCont];
        prescale_q <= wdata_i[CtrlPrescaleMsb:CtrlPrescaleLsb];
      end
    end
  end

  assign status_o   = {run_q, to_q};
  assign control_o  = {prescale_q, 6'b0, cont_q, ito_q};
  assign period_o   = period_q;
  assign snapshot_o = snapshot_q;
  assign irq_o      = to_q & ito_q;

endmodule

// File: rtl/sopc_multi_timer.sv
// Avalon-MM multi-channel interval timer: address decode, channel array, read mux, irq.
module sopc_multi_timer
  import sopc_multi_timer_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS   = 4,
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEFAULT_PERIOD = 49999,
  localparam int unsigned ADDR_WIDTH    = $clog2(NUM_CHANNELS) + 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    irq,
  output logic [NUM_CHANNELS-1:0] irq_vector
);

  logic [2:0]            reg_offset;
  int unsigned           chan_idx;
  logic                  bus_write;
  logic [DATA_WIDTH-1:0] rd_mux, readdata_q;

  logic [1:0]             status_arr   [NUM_CHANNELS];
  logic [15:0]            control_arr  [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0] period_arr   [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0] snapshot_arr [NUM_CHANNELS];

  assign reg_offset = address[2:0];
  assign chan_idx   = 32'(address >> 3);
  assign bus_write  = chipselect & ~write_n;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    logic sel;
    assign sel = bus_write && (chan_idx == unsigned'(i));

    sopc_multi_timer_channel #(
      .DATA_WIDTH     (DATA_WIDTH),
      .COUNT_WIDTH    (COUNT_WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_channel (
      .clk_i         (clk),
      .reset_ni      (reset_n),
      .status_we_i   (sel && (reg_offset == RegStatus)),
      .control_we_i  (sel && (reg_offset == RegControl)),
      .period_we_i   (sel && (reg_offset == RegPeriod)),
      .snapshot_we_i (sel && (reg_offset == RegSnapshot)),
      .wdata_i       (writedata),
      .status_o      (status_arr[i]),
      .control_o     (control_arr[i]),
      .period_o      (period_arr[i]),
      .snapshot_o    (snapshot_arr[i]),
      .irq_o         (irq_vector[i])
    );
  end

  // Unpopulated channel indices fall through and read as zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (chan_idx == i) begin
        case (reg_offset)
          RegStatus:   rd_mux = DATA_WIDTH'(status_arr[i]);
          RegControl:  rd_mux = DATA_WIDTH'(control_arr[i]);
          RegPeriod:   rd_mux = DATA_WIDTH'(period_arr[i]);
          RegSnapshot: rd_mux = DATA_WIDTH'(snapshot_arr[i]);
          RegPending:  rd_mux = DATA_WIDTH'(irq_vector);
          default:     rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= rd_mux;
  end

  assign readdata = readdata_q;
  assign irq      = |irq_vector;

endmodule

// File: tb/tb_sopc_multi_timer.sv
// Scoreboard bench for sopc_multi_timer: default build plus a 3-channel 16-bit build.
module tb_sopc_multi_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  address = '0;
  logic        cs_a = 1'b0, cs_b = 1'b0, write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;
  logic [3:0]  vec_a;
  logic [2:0]  vec_b;

  always #5 clk = ~clk;

  sopc_multi_timer u_dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (cs_a),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (rd_a),
    .irq        (irq_a),
    .irq_vector (vec_a)
  );

  sopc_multi_timer #(
    .NUM_CHANNELS (3),
    .COUNT_WIDTH  (16)
  ) u_dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (cs_b),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (rd_b),
    .irq        (irq_b),
    .irq_vector (vec_b)
  );

  typedef struct {
    string       name;
    bit          sel_b;
    logic [31:0] exp;
    bit          chk_irq;
    bit          exp_irq;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  logic rd_issue = 1'b0;
  logic rd_valid = 1'b0;

  // Read data is presented one cycle after the address.
  always @(posedge clk) rd_valid <= rd_issue;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    logic        act_irq;
    if (rd_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_response: got a read response with no expectation queued");
      end else begin
        e       = sb_q.pop_front();
        act     = e.sel_b ? rd_b : rd_a;
        act_irq = e.sel_b ? irq_b : irq_a;
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: readdata=%0h expected %0h", e.name, act, e.exp);
        end
        if (e.chk_irq) begin
          total++;
          if (act_irq !== e.exp_irq) begin
            bad++;
            $display("FAIL %s_irq: irq=%b expected %b", e.name, act_irq, e.exp_irq);
          end
        end
      end
    end
  end

  function automatic logic [4:0] ad(int ch, int off);
    return 5'(ch * 8 + off);
  endfunction

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(bit b, logic [4:0] a, logic [31:0] d);
    address = a; writedata = d; write_n = 1'b0; cs_a = !b; cs_b = b;
    cyc(1);
    cs_a = 1'b0; cs_b = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(bit b, logic [4:0] a, logic [31:0] exp, string name,
                    bit chk_irq = 1'b0, bit exp_irq = 1'b0);
    exp_t e;
    e.name = name; e.sel_b = b; e.exp = exp; e.chk_irq = chk_irq; e.exp_irq = exp_irq;
    sb_q.push_back(e);
    address = a; write_n = 1'b1; cs_a = !b; cs_b = b; rd_issue = 1'b1;
    cyc(1);
    cs_a = 1'b0; cs_b = 1'b0; rd_issue = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    cyc(3);
    reset_n = 1'b1;

    // Reset state of channel 0
    rd(0, ad(0, 0), 0, "rst_status", 1, 0);
    rd(0, ad(0, 1), 0, "rst_control");
    rd(0, ad(0, 2), 49999, "rst_period");
    rd(0, ad(0, 3), 0, "rst_snapshot");
    rd(0, ad(0, 4), 0, "rst_pending", 1, 0);
    rd(0, ad(0, 5), 0, "rst_off5");

    // ch1 continuous, period 9: TO visible 11 cycles after START, then every 10
    wr(0, ad(1, 2), 9);
    wr(0, ad(1, 1), 32'h7);
    cyc(9);
    rd(0, ad(1, 0), 2, "ch1_before_to");
    rd(0, ad(1, 0), 3, "ch1_first_to");
    rd(0, ad(0, 4), 2, "ch1_pending", 1, 1);
    rd(0, ad(1, 1), 3, "ch1_control_readback");
    wr(0, ad(1, 0), 1);
    rd(0, ad(1, 0), 2, "ch1_to_cleared", 1, 0);
    cyc(4);
    rd(0, ad(1, 0), 2, "ch1_before_second_to");
    rd(0, ad(1, 0), 3, "ch1_second_to");
    wr(0, ad(1, 0), 1);
    cyc(7);
    wr(0, ad(1, 0), 1);
    rd(0, ad(1, 0), 2, "ch1_clear_wins");
    wr(0, ad(1, 1), 32'h8);
    rd(0, ad(1, 0), 0, "ch1_stopped");

    // ch2 one-shot, period 4, prescale 3
    wr(0, ad(2, 2), 4);
    wr(0, ad(2, 1), 32'h304);
    cyc(4);
    wr(0, ad(2, 3), 0);
    rd(0, ad(2, 3), 3, "ch2_snap_first_tick");
    cyc(1);
    wr(0, ad(2, 3), 0);
    rd(0, ad(2, 3), 3, "ch2_snap_pre_decrement");
    wr(0, ad(2, 3), 0);
    rd(0, ad(2, 3), 2, "ch2_snap_second_tick");
    cyc(4);
    rd(0, ad(2, 0), 2, "ch2_running");
    rd(0, ad(2, 0), 2, "ch2_zero_reached");
    rd(0, ad(2, 0), 1, "ch2_oneshot_done");
    cyc(6);
    wr(0, ad(2, 3), 0);
    rd(0, ad(2, 3), 0, "ch2_holds_zero");
    rd(0, ad(2, 0), 1, "ch2_to_once");
    wr(0, ad(2, 0), 1);
    rd(0, ad(2, 0), 0, "ch2_no_reset_of_to");

    // ch0 running at 1000, then PERIOD=50 forces reload and stop
    wr(0, ad(0, 2), 1000);
    wr(0, ad(0, 1), 32'h6);
    cyc(5);
    wr(0, ad(0, 3), 0);
    rd(0, ad(0, 3), 995, "ch0_snap_running");
    wr(0, ad(0, 2), 50);
    cyc(1);
    rd(0, ad(0, 0), 0, "ch0_reload_stops");
    rd(0, ad(0, 2), 50, "ch0_period");
    wr(0, ad(0, 3), 0);
    rd(0, ad(0, 3), 50, "ch0_snap_reloaded");
    wr(0, ad(0, 1), 32'hC);
    rd(0, ad(0, 0), 2, "ch0_start_stop_start_wins");
    wr(0, ad(0, 1), 32'h8);
    rd(0, ad(0, 0), 0, "ch0_stop");

    // ch3 PERIOD=0 continuous: TO sets once, no re-set after clear
    wr(0, ad(3, 2), 0);
    wr(0, ad(3, 1), 32'h7);
    cyc(1);
    rd(0, ad(3, 0), 3, "ch3_p0_to");
    rd(0, ad(2, 4), 8, "ch3_pending", 1, 1);
    wr(0, ad(3, 0), 1);
    cyc(1);
    rd(0, ad(3, 0), 2, "ch3_p0_no_reset", 1, 0);
    wr(0, ad(3, 1), 32'h8);

    // Three-channel 16-bit build
    rd(1, ad(3, 2), 0, "b_ch3_period");
    rd(1, ad(3, 4), 0, "b_ch3_pending");
    wr(1, ad(3, 2), 5);
    wr(1, ad(3, 1), 32'h7);
    rd(1, ad(0, 2), 49999, "b_ch0_untouched");
    rd(1, ad(2, 0), 0, "b_ch2_untouched");
    rd(1, ad(0, 4), 0, "b_pending_idle", 1, 0);
    wr(1, ad(0, 2), 32'h12345);
    rd(1, ad(0, 2), 32'h2345, "b_period_truncated");
    for (int ch = 0; ch < 3; ch++) begin
      wr(1, ad(ch, 2), 3);
      wr(1, ad(ch, 1), 32'h7);
    end
    cyc(12);
    rd(1, ad(1, 4), 7, "b_pending_all", 1, 1);

    // Reset in the middle of a count
    wr(0, ad(0, 2), 20);
    wr(0, ad(0, 1), 32'h7);
    cyc(5);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    rd(0, ad(0, 0), 0, "mid_rst_status", 1, 0);
    rd(0, ad(0, 2), 49999, "mid_rst_period");
    rd(0, ad(0, 1), 0, "mid_rst_control");
    rd(0, ad(0, 3), 0, "mid_rst_snapshot");

    cyc(3);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: pending=%0d expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
